// File: rtl/lap_stopwatch.sv
// Run/pause/clear BCD stopwatch (M:SS.t) with prescaled 0.1 s tick,
// up/down counting, saturate-or-wrap at the top, and a lap display hold.
module lap_stopwatch #(
    parameter int unsigned TICK_DIV = 10_000_000,
    parameter int unsigned MAX_MIN  = 9,
    parameter bit          WRAP     = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        clear_i,
    input  logic        lap_i,
    input  logic        dir_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    output logic [3:0]  digit0_o,
    output logic [3:0]  digit1_o,
    output logic [3:0]  digit2_o,
    output logic [3:0]  digit3_o,
    output logic        running_o,
    output logic        lap_active_o,
    output logic        done_o,
    output logic        tick_o
);

    localparam int unsigned PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]  MIN_TOP    = 4'(MAX_MIN);
    localparam logic [15:0] TIME_MAX   = {MIN_TOP, 4'd5, 4'd9, 4'd9};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            dir_q, dir_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [15:0]     time_q, time_d;
    logic [15:0]     snap_q, snap_d;
    logic [15:0]     disp_q, disp_d;
    logic            lap_q, lap_d;
    logic            done_d, tick_d;

    logic            run_adv;
    logic            tick_cond;
    logic            start_ok;
    logic            at_max;
    logic [15:0]     time_inc;
    logic [15:0]     time_dec;
    logic            terminal;

    // BCD increment with full carry ripple; top wraps to zero
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [3:0] m, st, su, te;
        {m, st, su, te} = t;
        if (te != 4'd9) begin
            te = te + 4'd1;
        end else begin
            te = 4'd0;
            if (su != 4'd9) begin
                su = su + 4'd1;
            end else begin
                su = 4'd0;
                if (st != 4'd5) begin
                    st = st + 4'd1;
                end else begin
                    st = 4'd0;
                    m  = (m != MIN_TOP) ? m + 4'd1 : 4'd0;
                end
            end
        end
        return {m, st, su, te};
    endfunction

    // BCD decrement with full borrow ripple
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m, st, su, te;
        {m, st, su, te} = t;
        if (te != 4'd0) begin
            te = te - 4'd1;
        end else begin
            te = 4'd9;
            if (su != 4'd0) begin
                su = su - 4'd1;
            end else begin
                su = 4'd9;
                if (st != 4'd0) begin
                    st = st - 4'd1;
                end else begin
                    st = 4'd5;
                    m  = (m != 4'd0) ? m - 4'd1 : MIN_TOP;
                end
            end
        end
        return {m, st, su, te};
    endfunction

    // Per-field clamp of a loaded BCD value
    function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
        logic [3:0] m, st, su, te;
        m  = (v[15:12] > MIN_TOP) ? MIN_TOP : v[15:12];
        st = (v[11:8]  > 4'd5)    ? 4'd5    : v[11:8];
        su = (v[7:4]   > 4'd9)    ? 4'd9    : v[7:4];
        te = (v[3:0]   > 4'd9)    ? 4'd9    : v[3:0];
        return {m, st, su, te};
    endfunction

    // Shared decode: stop/clear pause the prescaler in the cycle they arrive
    always_comb begin
        run_adv   = (state_q == RUN) && !clear_i && !stop_i;
        tick_cond = run_adv && (presc_q == PRESC_LAST);
        at_max    = (time_q == TIME_MAX);
        time_inc  = bcd_inc(time_q);
        time_dec  = bcd_dec(time_q);
        start_ok  = (state_q == IDLE) && start_i && !clear_i && !load_i && !stop_i
                    && !(dir_i && (time_q == 16'h0000));
        terminal  = tick_cond && (dir_q ? (time_dec == 16'h0000) : (at_max && !WRAP));
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_ok) state_d = RUN;
            RUN:  if (clear_i || stop_i || terminal) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: time, prescaler, lap snapshot, pulses, display
    always_comb begin
        time_d  = time_q;
        snap_d  = snap_q;
        lap_d   = lap_q;
        presc_d = presc_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        tick_d  = 1'b0;
        if (clear_i) begin
            time_d  = 16'h0000;
            snap_d  = 16'h0000;
            lap_d   = 1'b0;
            presc_d = '0;
        end else begin
            if (load_i && (state_q == IDLE)) begin
                time_d = bcd_clamp(load_val_i);
            end
            if (start_ok) begin
                dir_d = dir_i;
            end
            if (run_adv) begin
                presc_d = tick_cond ? '0 : presc_q + PW'(1);
            end
            if (tick_cond) begin
                if (dir_q) begin
                    time_d = time_dec;
                    tick_d = 1'b1;
                    done_d = (time_dec == 16'h0000);
                end else if (at_max && !WRAP) begin
                    done_d = 1'b1;
                end else begin
                    time_d = time_inc;
                    tick_d = 1'b1;
                end
            end
            if (lap_i) begin
                if (!lap_q) begin
                    snap_d = time_q;
                    lap_d  = 1'b1;
                end else begin
                    lap_d  = 1'b0;
                end
            end
        end
        disp_d = lap_d ? snap_d : time_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            time_q  <= 16'h0000;
            snap_q  <= 16'h0000;
            disp_q  <= 16'h0000;
            lap_q   <= 1'b0;
            presc_q <= '0;
            dir_q   <= 1'b0;
            done_o  <= 1'b0;
            tick_o  <= 1'b0;
        end else begin
            time_q  <= time_d;
            snap_q  <= snap_d;
            disp_q  <= disp_d;
            lap_q   <= lap_d;
            presc_q <= presc_d;
            dir_q   <= dir_d;
            done_o  <= done_d;
            tick_o  <= tick_d;
        end
    end

    assign digit0_o     = disp_q[3:0];
    assign digit1_o     = disp_q[7:4];
    assign digit2_o     = disp_q[11:8];
    assign digit3_o     = disp_q[15:12];
    assign running_o    = (state_q == RUN);
    assign lap_active_o = lap_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: saturating and wrapping instances share stimulus and
// are compared every cycle against a tenths-count model, plus literal anchors.
module tb_lap_stopwatch;

    localparam int TD   = 4;
    localparam int MM   = 9;
    localparam int MAXT = MM * 600 + 599;

    logic        clk = 1'b0;
    logic        rst_ni, start_i, stop_i, clear_i, lap_i, dir_i, load_i;
    logic [15:0] load_val_i;

    logic [3:0] s_d0, s_d1, s_d2, s_d3, w_d0, w_d1, w_d2, w_d3;
    logic       s_run, s_lap, s_done, s_tick, w_run, w_lap, w_done, w_tick;

    lap_stopwatch #(.TICK_DIV(TD), .MAX_MIN(MM), .WRAP(1'b0)) dut_sat (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
        .clear_i(clear_i), .lap_i(lap_i), .dir_i(dir_i), .load_i(load_i),
        .load_val_i(load_val_i),
        .digit0_o(s_d0), .digit1_o(s_d1), .digit2_o(s_d2), .digit3_o(s_d3),
        .running_o(s_run), .lap_active_o(s_lap), .done_o(s_done), .tick_o(s_tick)
    );

    lap_stopwatch #(.TICK_DIV(TD), .MAX_MIN(MM), .WRAP(1'b1)) dut_wrap (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
        .clear_i(clear_i), .lap_i(lap_i), .dir_i(dir_i), .load_i(load_i),
        .load_val_i(load_val_i),
        .digit0_o(w_d0), .digit1_o(w_d1), .digit2_o(w_d2), .digit3_o(w_d3),
        .running_o(w_run), .lap_active_o(w_lap), .done_o(w_done), .tick_o(w_tick)
    );

    always #5 clk = ~clk;

    // Model: time held as a plain count of tenths
    int m_t[2], m_snap[2], m_presc[2];
    bit m_run[2], m_down[2], m_lap[2], m_done[2], m_tick[2];

    int n_pass = 0, n_total = 0;
    int tick_cnt, done_cnt, done_tick_cnt;

    function automatic int clamp_val(input logic [15:0] v);
        int m, st, su, te;
        m  = int'(v[15:12]); if (m > MM) m = MM;
        st = int'(v[11:8]);  if (st > 5) st = 5;
        su = int'(v[7:4]);   if (su > 9) su = 9;
        te = int'(v[3:0]);   if (te > 9) te = 9;
        return m * 600 + st * 100 + su * 10 + te;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 600), 4'((n % 600) / 100), 4'((n % 100) / 10), 4'(n % 10)};
    endfunction

    task automatic model_step(input int k, input bit wrap);
        int cur;
        m_done[k] = 1'b0;
        m_tick[k] = 1'b0;
        if (!rst_ni || clear_i) begin
            m_t[k] = 0; m_snap[k] = 0; m_presc[k] = 0;
            m_run[k] = 1'b0; m_lap[k] = 1'b0;
            if (!rst_ni) m_down[k] = 1'b0;
            return;
        end
        cur = m_t[k];
        if (!m_run[k]) begin
            if (load_i) m_t[k] = clamp_val(load_val_i);
            else if (start_i && !stop_i && !(dir_i && cur == 0)) begin
                m_run[k]  = 1'b1;
                m_down[k] = dir_i;
            end
        end else if (stop_i) begin
            m_run[k] = 1'b0;
        end else if (m_presc[k] == TD - 1) begin
            m_presc[k] = 0;
            if (m_down[k]) begin
                m_t[k] = cur - 1;
                m_tick[k] = 1'b1;
                if (m_t[k] == 0) begin m_done[k] = 1'b1; m_run[k] = 1'b0; end
            end else if (cur == MAXT) begin
                if (wrap) begin m_t[k] = 0; m_tick[k] = 1'b1; end
                else begin m_done[k] = 1'b1; m_run[k] = 1'b0; end
            end else begin
                m_t[k] = cur + 1;
                m_tick[k] = 1'b1;
            end
        end else begin
            m_presc[k] = m_presc[k] + 1;
        end
        if (lap_i) begin
            if (!m_lap[k]) begin m_snap[k] = cur; m_lap[k] = 1'b1; end
            else m_lap[k] = 1'b0;
        end
    endtask

    function automatic logic [19:0] model_vec(input int k);
        return {to_bcd(m_lap[k] ? m_snap[k] : m_t[k]), m_run[k], m_lap[k], m_done[k], m_tick[k]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // One clock: model and DUT advance on the edge, outputs compared 1 time unit later
    task automatic cycle();
        @(posedge clk);
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        #1;
        check("sat_cycle",  32'({s_d3, s_d2, s_d1, s_d0, s_run, s_lap, s_done, s_tick}), 32'(model_vec(0)));
        check("wrap_cycle", 32'({w_d3, w_d2, w_d1, w_d0, w_run, w_lap, w_done, w_tick}), 32'(model_vec(1)));
        if (s_tick) tick_cnt++;
        if (s_done) done_cnt++;
        if (s_done && s_tick) done_tick_cnt++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    function automatic logic [15:0] sdisp();
        return {s_d3, s_d2, s_d1, s_d0};
    endfunction

    function automatic logic [15:0] wdisp();
        return {w_d3, w_d2, w_d1, w_d0};
    endfunction

    task automatic reset_counts();
        tick_cnt = 0; done_cnt = 0; done_tick_cnt = 0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1; cycle(); clear_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0;
        lap_i = 1'b0; dir_i = 1'b0; load_i = 1'b0; load_val_i = 16'h0000;
        reset_counts();
        run(3);
        check("rst_digits", 32'(sdisp()), 32'h0000);
        check("rst_running", 32'(s_run), 32'h0);
        rst_ni = 1'b1;
        run(2);

        // Count up 40 cycles
        reset_counts();
        start_i = 1'b1; cycle(); start_i = 1'b0;
        run(40);
        check("up40_digits", 32'(sdisp()), 32'h0010);
        check("up40_running", 32'(s_run), 32'h1);
        check("up40_ticks", 32'(tick_cnt), 32'd10);

        // Top of range: saturate vs wrap
        do_clear();
        load_i = 1'b1; load_val_i = 16'h9599; cycle(); load_i = 1'b0;
        reset_counts();
        start_i = 1'b1; cycle(); start_i = 1'b0;
        run(4);
        check("sat_digits", 32'(sdisp()), 32'h9599);
        check("sat_running", 32'(s_run), 32'h0);
        check("sat_done_cnt", 32'(done_cnt), 32'd1);
        check("sat_done_no_tick", 32'(done_tick_cnt), 32'd0);
        check("wrap_digits", 32'(wdisp()), 32'h0000);
        check("wrap_running", 32'(w_run), 32'h1);
        do_clear();

        // Count down from 0:01.0
        load_i = 1'b1; load_val_i = 16'h0010; cycle(); load_i = 1'b0;
        reset_counts();
        dir_i = 1'b1; start_i = 1'b1; cycle(); start_i = 1'b0; dir_i = 1'b0;
        run(40);
        check("down_digits", 32'(sdisp()), 32'h0000);
        check("down_running", 32'(s_run), 32'h0);
        check("down_done_cnt", 32'(done_cnt), 32'd1);
        check("down_done_with_tick", 32'(done_tick_cnt), 32'd1);

        // Down start at zero is ignored
        dir_i = 1'b1; start_i = 1'b1; cycle(); start_i = 1'b0; dir_i = 1'b0;
        check("down_zero_ignored", 32'(s_run), 32'h0);

        // Lap hold while running
        do_clear();
        start_i = 1'b1; cycle(); start_i = 1'b0;
        run(92);
        lap_i = 1'b1; cycle(); lap_i = 1'b0;
        check("lap_hold", 32'({sdisp(), s_lap, s_run}), 32'({16'h0023, 1'b1, 1'b1}));
        run(20);
        check("lap_hold_later", 32'(sdisp()), 32'h0023);
        run(87);
        lap_i = 1'b1; cycle(); lap_i = 1'b0;
        check("lap_release", 32'({sdisp(), s_lap}), 32'({16'h0050, 1'b0}));

        // clear beats start; stop beats start and holds prescaler phase
        clear_i = 1'b1; start_i = 1'b1; cycle(); clear_i = 1'b0; start_i = 1'b0;
        check("clear_start", 32'({sdisp(), s_run}), 32'({16'h0000, 1'b0}));
        start_i = 1'b1; cycle(); start_i = 1'b0;
        run(5);
        stop_i = 1'b1; start_i = 1'b1; cycle(); stop_i = 1'b0; start_i = 1'b0;
        check("stop_start", 32'({sdisp(), s_run}), 32'({16'h0001, 1'b0}));
        start_i = 1'b1; cycle(); start_i = 1'b0;
        run(2);
        check("resume_pre_tick", 32'({sdisp(), s_tick}), 32'({16'h0001, 1'b0}));
        run(1);
        check("resume_tick", 32'({sdisp(), s_tick}), 32'({16'h0002, 1'b1}));
        stop_i = 1'b1; cycle(); stop_i = 1'b0;
        load_i = 1'b1; load_val_i = 16'hFFFF; cycle(); load_i = 1'b0;
        check("load_clamp", 32'(sdisp()), 32'h9599);

        // Reset mid-run with lap active
        do_clear();
        start_i = 1'b1; cycle(); start_i = 1'b0;
        run(40);
        lap_i = 1'b1; cycle(); lap_i = 1'b0;
        run(107);
        check("pre_rst_lap", 32'({sdisp(), s_lap}), 32'({16'h0010, 1'b1}));
        rst_ni = 1'b0; cycle(); rst_ni = 1'b1;
        check("mid_rst", 32'({sdisp(), s_run, s_lap, s_done, s_tick}), 32'h0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            start_i = ($urandom_range(0, 99) < 8);
            stop_i  = ($urandom_range(0, 99) < 3);
            clear_i = ($urandom_range(0, 199) < 1);
            lap_i   = ($urandom_range(0, 99) < 3);
            load_i  = ($urandom_range(0, 99) < 5);
            dir_i   = 1'($urandom_range(0, 1));
            rst_ni  = !($urandom_range(0, 499) < 1);
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: load_val_i = 16'($urandom);
                1: load_val_i = 16'h9599;
                2: load_val_i = 16'h9598;
                3: load_val_i = 16'h0001;
                default: load_val_i = 16'h0002;
            endcase
            cycle();
        end
        start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0; lap_i = 1'b0;
        load_i = 1'b0; rst_ni = 1'b1;
        run(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
